// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexing scanner for a common-anode multi-digit seven-segment
// display. One shared BCD-to-segment decoder is driven with one nibble at a
// time while the matching anode is pulled low. Each digit slot starts with a
// short all-dark blanking window to suppress ghosting. Digit values and
// decimal-point requests are captured once per frame so a value that changes
// mid-frame never tears across positions.
//
// Parameters:
//   DIGITS       number of digit positions (2..8)
//   SCAN_DIV     clock cycles per digit slot (>= 4)
//   BLANK_CYCLES dark cycles at the start of every slot (1..SCAN_DIV-1)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   scan enable; low = display dark, scan held at slot 0
//   digits      in   packed BCD, nibble k = position k (k=0 rightmost)
//   dp_mask     in   decimal-point request per position, active-high
//   lz_en       in   leading-zero suppression enable
//   digit_code  out  code for the shared decoder (4'hF = blank)
//   an_n        out  anode enables, active-low, at most one low
//   dp_n        out  decimal point, active-low
//   frame_done  out  one-cycle pulse on the edge a new frame begins
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_en,
  output logic [3:0]            digit_code,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(DIGITS - 1);
  localparam logic [3:0]        CODE_BLANK = 4'hF;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    r_cnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [4*DIGITS-1:0] r_shadow;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic                r_loaded;     // a snapshot has been taken since enable
  logic [3:0]          r_digit_code;
  logic [DIGITS-1:0]   r_an_n;
  logic                r_dp_n;
  logic                r_frame_done;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    w_cnt_next;
  logic [SLOT_W-1:0]   w_slot_next;
  logic [4*DIGITS-1:0] w_shadow_next;
  logic [DIGITS-1:0]   w_shadow_dp_next;
  logic                w_loaded_next;
  logic                w_cnt_end;
  logic                w_frame_end;
  logic                w_load;

  always_comb begin
    w_cnt_end     = (r_cnt == CNT_MAX);
    w_frame_end   = w_cnt_end && (r_slot == SLOT_MAX);
    // Snapshot either when a frame wraps or on the very first enabled cycle
    // (cnt/slot are already 0 then because disable forces them there).
    w_load        = en && (!r_loaded || w_frame_end);

    w_cnt_next    = '0;
    w_slot_next   = '0;
    w_loaded_next = 1'b0;
    if (en) begin
      w_loaded_next = 1'b1;
      if (w_cnt_end) begin
        w_cnt_next  = '0;
        w_slot_next = (r_slot == SLOT_MAX) ? '0 : r_slot + 1'b1;
      end else begin
        w_cnt_next  = r_cnt + 1'b1;
        w_slot_next = r_slot;
      end
    end

    w_shadow_next    = w_load ? digits  : r_shadow;
    w_shadow_dp_next = w_load ? dp_mask : r_shadow_dp;
  end

  // ---------------------------------------------------------------------------
  // Per-position decode: slot select, nibble split, leading-zero suppression.
  // Everything is derived from the next-state shadow so the registered
  // outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  logic [3:0]        w_nib [DIGITS];
  logic [DIGITS-1:0] w_sel;
  logic [DIGITS-1:0] w_supp;
  // w_hi_zero[k]: nibbles k..DIGITS-1 are all zero
  logic [DIGITS-1:1] w_hi_zero;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
    assign w_nib[gi] = w_shadow_next[4*gi +: 4];
    assign w_sel[gi] = (w_slot_next == SLOT_W'(gi));

    if (gi == 0) begin : g_lsd
      // Rightmost digit always shows, so a value of zero reads "0".
      assign w_supp[gi] = 1'b0;
    end else if (gi == DIGITS - 1) begin : g_msd
      assign w_hi_zero[gi] = (w_nib[gi] == 4'h0);
      assign w_supp[gi]    = lz_en && w_hi_zero[gi];
    end else begin : g_mid
      assign w_hi_zero[gi] = (w_nib[gi] == 4'h0) && w_hi_zero[gi+1];
      assign w_supp[gi]    = lz_en && w_hi_zero[gi];
    end
  end

  // ---------------------------------------------------------------------------
  // Output next values
  // ---------------------------------------------------------------------------
  logic [3:0]        w_cur_nib;
  logic              w_cur_dp;
  logic              w_cur_supp;
  logic              w_blank;
  logic [3:0]        w_digit_code_next;
  logic [DIGITS-1:0] w_an_n_next;
  logic              w_dp_n_next;
  logic              w_frame_done_next;

  always_comb begin
    w_cur_nib  = 4'h0;
    w_cur_dp   = 1'b0;
    w_cur_supp = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_sel[k]) begin
        w_cur_nib  = w_nib[k];
        w_cur_dp   = w_shadow_dp_next[k];
        w_cur_supp = w_supp[k];
      end
    end

    w_blank = (w_cnt_next < BLANK_END);

    w_digit_code_next = CODE_BLANK;
    w_an_n_next       = '1;
    w_dp_n_next       = 1'b1;
    w_frame_done_next = 1'b0;

    if (en) begin
      // The code only changes at slot/frame boundaries, i.e. at cnt 0, which
      // is always inside the blanking window, so no anode is lit while it
      // settles.
      w_digit_code_next = w_cur_supp ? CODE_BLANK : w_cur_nib;
      w_an_n_next       = w_blank ? '1 : ~w_sel;
      w_dp_n_next       = (w_blank || w_cur_supp) ? 1'b1 : ~w_cur_dp;
      w_frame_done_next = w_frame_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_slot       <= '0;
      r_shadow     <= '1;
      r_shadow_dp  <= '0;
      r_loaded     <= 1'b0;
      r_digit_code <= CODE_BLANK;
      r_an_n       <= '1;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_slot       <= w_slot_next;
      r_shadow     <= w_shadow_next;
      r_shadow_dp  <= w_shadow_dp_next;
      r_loaded     <= w_loaded_next;
      r_digit_code <= w_digit_code_next;
      r_an_n       <= w_an_n_next;
      r_dp_n       <= w_dp_n_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign digit_code = r_digit_code;
  assign an_n       = r_an_n;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule
